// File: rtl/vga_capture_pkg.sv
// vga_capture_pkg: shared state encoding, default 640x480@60 timing and
// CRC-16-CCITT constants for the VGA capture block.
package vga_capture_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_H_OFFSET = 144;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_V_OFFSET = 35;
  localparam int VGA_V_ACTIVE = 480;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/vga_crc16.sv
// vga_crc16: one combinational CRC-16-CCITT step over a 16-bit word, MSB first.
module vga_crc16
  import vga_capture_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  // Shift the word in bit by bit, most significant bit first.
  always_comb begin
    c = crc_i;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data_i[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                   c = {c[14:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/vga_capture.sv
// vga_capture: samples hsync/vsync/RGB565 on pix_en, recovers line/frame
// timing from sync assertion edges, verifies line and frame lengths and
// emits one strobe per active pixel with its x, y and colour.
// Optional feature macro VGA_CAPTURE_CRC_EN adds frame_crc/crc_valid: a
// CRC-16-CCITT over every active pixel of each fully locked frame.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int H_OFFSET = VGA_H_OFFSET,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int V_OFFSET = VGA_V_OFFSET,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
`ifdef VGA_CAPTURE_CRC_EN
  output logic [15:0] frame_crc,
  output logic        crc_valid,
`endif
  output logic        sync_err
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_MISS  = 11'(H_TOTAL + H_TOTAL / 2);
  localparam logic [10:0] H_SAT   = 11'h7FF;
  localparam logic [10:0] H_FIRST = 11'(H_OFFSET);
  localparam logic [10:0] H_END   = 11'(H_OFFSET + H_ACTIVE - 1);
  localparam logic [9:0]  V_FULL  = 10'(V_TOTAL);
  localparam logic [9:0]  V_FIRST = 10'(V_OFFSET);
  localparam logic [9:0]  V_END   = 10'(V_OFFSET + V_ACTIVE - 1);

  // Sampled syncs are stored normalised: 1 means "at the active level".
  logic        smp_vld_q;
  logic        hs_cur_q, hs_prev_q, vs_cur_q, vs_prev_q;
  logic [15:0] rgb_smp_q;
  logic        hs_edge, vs_edge;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  state_e      state_q, state_d;
  logic        exempt_q, exempt_d;
  logic        h_bad, v_bad, h_miss, viol;

  logic        act_d;
  logic [9:0]  x_d, y_d;

  logic        pix_valid_q, frame_start_q, locked_q, sync_err_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [15:0] pix_rgb_q;

  // Input stage: capture sync levels and remember the previous sample.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      smp_vld_q <= 1'b0;
      hs_cur_q  <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_cur_q  <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      smp_vld_q <= pix_en;
      if (pix_en) begin
        hs_cur_q  <= (hsync == SYNC_POL);
        hs_prev_q <= hs_cur_q;
        vs_cur_q  <= (vsync == SYNC_POL);
        vs_prev_q <= vs_cur_q;
      end
    end
  end

  // Pixel data is only meaningful alongside a sample, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (pix_en) rgb_smp_q <= rgb;
  end

  assign hs_edge = smp_vld_q && hs_cur_q && !hs_prev_q;
  assign vs_edge = smp_vld_q && vs_cur_q && !vs_prev_q;

  // Counter next-state: hsync restarts the line, vsync restarts the frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (smp_vld_q) begin
      if (hs_edge)               h_cnt_d = '0;
      else if (h_cnt_q != H_SAT) h_cnt_d = h_cnt_q + 11'd1;
      if (vs_edge)      v_cnt_d = hs_edge ? 10'd1 : 10'd0;
      else if (hs_edge) v_cnt_d = v_cnt_q + 10'd1;
    end
  end

  // Length checks look at the counts accumulated before this sample.
  assign h_bad  = hs_edge && (h_cnt_q != H_LAST) && !exempt_q;
  assign v_bad  = vs_edge && (v_cnt_q != V_FULL);
  assign h_miss = smp_vld_q && !hs_edge && (h_cnt_d == H_MISS);

  // Lock FSM next-state; the first hsync after acquire entry may be partial.
  always_comb begin
    state_d  = state_q;
    exempt_d = exempt_q;
    viol     = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        if (vs_edge) begin
          state_d  = ACQUIRE;
          exempt_d = 1'b1;
        end
      end
      ACQUIRE: begin
        if (h_bad || v_bad || h_miss) begin
          viol    = 1'b1;
          state_d = UNLOCKED;
        end else if (vs_edge) begin
          state_d = LOCKED;
        end
        if (hs_edge) exempt_d = 1'b0;
      end
      LOCKED: begin
        exempt_d = 1'b0;
        if (h_bad || v_bad || h_miss) begin
          viol    = 1'b1;
          state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Timing state: counters, lock state and the acquire exemption flag.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      state_q  <= UNLOCKED;
      exempt_q <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      state_q  <= state_d;
      exempt_q <= exempt_d;
    end
  end

  assign act_d = smp_vld_q && (state_q == LOCKED) &&
                 (h_cnt_d >= H_FIRST) && (h_cnt_d <= H_END) &&
                 (v_cnt_d >= V_FIRST) && (v_cnt_d <= V_END);
  assign x_d   = 10'(h_cnt_d - H_FIRST);
  assign y_d   = 10'(v_cnt_d - V_FIRST);

  // Output stage: pixel strobe and coordinates, lock flag and error pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      pix_valid_q   <= act_d;
      frame_start_q <= act_d && (x_d == 10'd0) && (y_d == 10'd0);
      if (act_d) begin
        pix_x_q   <= x_d;
        pix_y_q   <= y_d;
        pix_rgb_q <= rgb_smp_q;
      end
      locked_q      <= (state_q == LOCKED);
      sync_err_q    <= viol;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

`ifdef VGA_CAPTURE_CRC_EN
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  logic        last_q, crc_ok_q, crc_valid_q;
  logic [15:0] crc_q, frame_crc_q, crc_step;

  vga_crc16 u_crc (
    .crc_i  (frame_start_q ? CRC_INIT : crc_q),
    .data_i (pix_rgb_q),
    .crc_o  (crc_step)
  );

  // Marks the final active pixel so the CRC can be published behind it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) last_q <= 1'b0;
    else         last_q <= act_d && (x_d == X_LAST) && (y_d == Y_LAST);
  end

  // Running CRC; a frame only publishes if lock held since its first pixel.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      crc_q       <= '0;
      frame_crc_q <= '0;
      crc_ok_q    <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= 1'b0;
      if (pix_valid_q) begin
        crc_q <= crc_step;
        if (frame_start_q) crc_ok_q <= 1'b1;
        if (last_q && (crc_ok_q || frame_start_q)) begin
          frame_crc_q <= crc_step;
          crc_valid_q <= 1'b1;
        end
      end
      if (state_q != LOCKED) crc_ok_q <= 1'b0;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`endif

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA timing generator in the simulation board. It samples the generator's `hsync`, `vsync` and 16-bit RGB565 bus on the 50 MHz system clock, qualified by a pixel enable. It recovers frame and line timing from the sync edges, verifies line and frame lengths against parameters, and emits one pixel strobe per active pixel carrying x, y and colour. The bench uses it to check generator output pixel-by-pixel without a screen.

## Interface
- `H_TOTAL`, default 800: pixel clocks per line.
- `H_OFFSET`, default 144: pixels from the hsync assertion edge to the first active pixel.
- `H_ACTIVE`, default 640: active pixels per line.
- `V_TOTAL`, default 525: lines per frame.
- `V_OFFSET`, default 35: hsync assertion edges from the vsync assertion edge to the first active line.
- `V_ACTIVE`, default 480: active lines per frame.
- `SYNC_POL`, default 0: sync active level (0 = active-low).
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `pix_en`  in  1  pixel clock enable; one pixel is sampled per asserted cycle.
- `hsync`, `vsync`  in  1 each  sync inputs from the generator.
- `rgb`  in  16  RGB565 pixel.
- `pix_valid`  out  1  one-cycle strobe for one active pixel.
- `pix_x`  out  10  active column.
- `pix_y`  out  10  active row.
- `pix_rgb`  out  16  pixel colour.
- `frame_start`  out  1  pulses together with `pix_valid` at x=0, y=0.
- `locked`  out  1  timing verified; pixel output is enabled.
- `sync_err`  out  1  one-cycle pulse on any timing violation.

## Operation
- **Input stage:** `hsync`, `vsync` and `rgb` are registered on `pix_en` cycles. An assertion edge is a sample at the active level following a sample at the inactive level. All counters advance only on `pix_en`.
- **Horizontal counter:** 11-bit `h_cnt`. An hsync assertion edge loads 0; otherwise the counter increments, saturating at 2047.
- **Vertical counter:** 10-bit `v_cnt`. It increments on each hsync edge.
  - A vsync edge loads 0.
  - If the vsync edge and an hsync edge fall in the same sample, it loads 1.
- **Active pixel:** state is LOCKED, `h_cnt` is in [H_OFFSET, H_OFFSET+H_ACTIVE-1], and `v_cnt` is in [V_OFFSET, V_OFFSET+V_ACTIVE-1].
  - x = `h_cnt` − H_OFFSET.
  - y = `v_cnt` − V_OFFSET.
- **Checks** (use counter values before the current sample updates them):
  - On an hsync edge, `h_cnt` must equal H_TOTAL−1.
  - On a vsync edge, `v_cnt` must equal V_TOTAL.
  - `h_cnt` reaching H_TOTAL+H_TOTAL/2 without an hsync edge is a violation (missing hsync).
- **FSM:**
  - UNLOCKED: wait for a vsync edge → ACQUIRE. Checks are ignored.
  - ACQUIRE: all checks are active, except that the first hsync edge after entry is exempt. A vsync edge with a correct `v_cnt` → LOCKED. Any violation → UNLOCKED.
  - LOCKED: pixel output is enabled. Any violation → UNLOCKED.
- **On a violation** (ACQUIRE or LOCKED only): `sync_err` pulses and the FSM goes to UNLOCKED. A vsync edge that is itself the violation does not re-enter ACQUIRE in the same cycle.

## Timing
- Reset value of every output is 0. State resets to UNLOCKED and both counters reset to 0.
- Asserting `sys_rst` mid-frame clears everything immediately. After release, the block needs one full verified frame before `locked` rises again.
- Latency: `pix_valid`, `pix_x`, `pix_y`, `pix_rgb` and `frame_start` are registered outputs, 2 `sys_clk` cycles after the `pix_en` cycle that carried the pixel.
- `locked` rises and falls 1 cycle after the corresponding FSM transition.
- `sync_err` pulses 2 cycles after the offending sample.
- There is no back-pressure; a downstream consumer must accept one pixel per `pix_en`.
- `pix_x`, `pix_y` and `pix_rgb` hold their last values while `pix_valid` is low.

## Configuration
- Macro: `VGA_CAPTURE_CRC_EN`.
- **Defined:** the block adds outputs `frame_crc[15:0]` and `crc_valid`.
  - Algorithm: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, over each active `pix_rgb` word, MSB first.
  - The CRC restarts at `frame_start`.
  - `crc_valid` pulses 1 cycle after the `pix_valid` for pixel (H_ACTIVE−1, V_ACTIVE−1).
  - `frame_crc` holds its value until the next pulse.
  - Loss of lock mid-frame suppresses that frame's `crc_valid`.
- **Undefined:** the ports and logic are absent.

## Structure
- Package `vga_capture_pkg` holds:
  - the state enum (UNLOCKED, ACQUIRE, LOCKED);
  - the default 640×480@60 timing constants;
  - the CRC polynomial and init constants.
- Sub-module `vga_crc16`: a purely combinational one-word CRC step, instantiated only under `VGA_CAPTURE_CRC_EN`.

## Test plan
- **Clean 640×480 frames, counting-pattern rgb** (rgb = x^y), `pix_en` every other cycle:
  - `locked` rises after the first complete frame.
  - Exactly 307200 `pix_valid` pulses occur per frame, with matching x, y and rgb.
  - `frame_start` fires only at (0,0).
- **One line of 801 pixels in a locked frame:** a `sync_err` pulse; `locked` goes to 0; reacquisition occurs after two further frames.
- **Frame of 524 lines:** `sync_err` on the vsync edge; no pixels are output until relock.
- **hsync held inactive for 1200 pixels:** missing-hsync `sync_err`; UNLOCKED.
- **`sys_rst` pulse at line 200:** all outputs are 0 next cycle; no `pix_valid` until one verified frame has passed.
- **CRC (with `VGA_CAPTURE_CRC_EN`):** an all-0x0000 frame and a constant 0xF800 frame give `frame_crc` equal to the golden model, with one `crc_valid` per frame.
